temperature_sensor_reader: RTL and testbench

Front end of the hotend temperature loop. Reads the thermistor divider through an external 10-bit SPI ADC (MCP3002-style, channel 0) at a fixed rate. Averages a window of samples, scales the average to the 8-bit live-temperature code, and presents it to the temperature regulator's live input. It also flags an open or shorted sensor and forces a heater-off reading while the fault is present.

---
 rtl/temperature_sensor_reader.sv | 168 ++++++++++++++++
 tb/tb_temperature_sensor_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/temperature_sensor_reader.sv
// rtl/temperature_sensor_reader.sv - SPI thermistor ADC reader with windowed averaging, scaling and railed-sensor fault
module temperature_sensor_reader #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int AVG_LOG2      = 3,
    parameter int ADC_OFFSET    = 0,
    parameter int ADC_SHIFT     = 2
) (
    input  logic       i_Clock50MHz,
    input  logic       i_Reset,
    input  logic       i_Adc_Miso,
    output logic       o_Adc_Sclk,
    output logic       o_Adc_Mosi,
    output logic       o_Adc_Cs_n,
    output logic [7:0] o_Live,
    output logic       o_Live_Valid,
    output logic       o_Sensor_Fault
);

    localparam int TW = $clog2(SAMPLE_PERIOD + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int AW = 10 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_ACCUM   = 3'd4;
    localparam logic [2:0] S_PUBLISH = 3'd5;

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [DW-1:0] r_div;
    logic [4:0]    r_half;
    logic [9:0]    r_shift;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_count;
    logic          r_win_fault;

    logic       w_req;
    logic       w_div_done;
    logic [3:0] w_rise_idx;
    logic [4:0] w_next_cmd_idx;
    logic       w_capture;
    logic [9:0] w_avg;
    logic [9:0] w_diff;
    logic [9:0] w_scaled;
    logic [7:0] w_live;

    // MCP3002 command: start, single-ended, channel 0, MSB first
    function automatic logic cmd_bit(input logic [4:0] idx);
        return (idx == 5'd0) || (idx == 5'd1) || (idx == 5'd3);
    endfunction

    assign w_req          = (r_timer == TW'(SAMPLE_PERIOD - 1));
    assign w_div_done     = (r_div == DW'(CLK_DIV - 1));
    assign w_rise_idx     = 4'((r_half + 5'd1) >> 1);
    assign w_next_cmd_idx = {1'b0, r_half[4:1]} + 5'd1;
    assign w_capture      = (w_rise_idx >= 4'd5) && (w_rise_idx <= 4'd14);

    assign w_avg = r_acc[AW-1:AVG_LOG2];

    always_comb begin
        w_diff = 10'd0;
        if (32'(w_avg) >= 32'(ADC_OFFSET)) begin
            w_diff = 10'(32'(w_avg) - 32'(ADC_OFFSET));
        end
        w_scaled = w_diff >> ADC_SHIFT;
        w_live   = (w_scaled > 10'd255) ? 8'hFF : w_scaled[7:0];
    end

    always_ff @(posedge i_Clock50MHz or posedge i_Reset) begin
        if (i_Reset) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_div          <= '0;
            r_half         <= '0;
            r_shift        <= '0;
            r_acc          <= '0;
            r_count        <= '0;
            r_win_fault    <= 1'b0;
            o_Adc_Sclk     <= 1'b0;
            o_Adc_Mosi     <= 1'b0;
            o_Adc_Cs_n     <= 1'b1;
            o_Live         <= 8'hFF;
            o_Live_Valid   <= 1'b0;
            o_Sensor_Fault <= 1'b0;
        end else begin
            r_timer      <= w_req ? '0 : r_timer + 1'b1;
            o_Live_Valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // requests seen outside IDLE are simply lost
                    if (w_req) begin
                        r_state    <= S_SETUP;
                        r_div      <= '0;
                        o_Adc_Cs_n <= 1'b0;
                        o_Adc_Sclk <= 1'b0;
                        o_Adc_Mosi <= cmd_bit(5'd0);
                    end
                end
                S_SETUP: begin
                    if (w_div_done) begin
                        r_state    <= S_SHIFT;
                        r_div      <= '0;
                        r_half     <= '0;
                        o_Adc_Sclk <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        if (r_half == 5'd31) begin
                            r_state    <= S_HOLD;
                            o_Adc_Cs_n <= 1'b1;
                            o_Adc_Sclk <= 1'b0;
                            o_Adc_Mosi <= 1'b0;
                        end else begin
                            r_half     <= r_half + 5'd1;
                            o_Adc_Sclk <= ~o_Adc_Sclk;
                            // odd half ends low, so the next toggle is a rising edge
                            if (r_half[0]) begin
                                if (w_capture) begin
                                    r_shift <= {r_shift[8:0], i_Adc_Miso};
                                end
                            end else begin
                                o_Adc_Mosi <= cmd_bit(w_next_cmd_idx);
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_div_done) begin
                        r_state <= S_ACCUM;
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_acc   <= r_acc + AW'(r_shift);
                    r_count <= r_count + 1'b1;
                    if ((r_shift == 10'h000) || (r_shift == 10'h3FF)) begin
                        r_win_fault <= 1'b1;
                    end
                    r_state <= (r_count == LAST_SAMPLE) ? S_PUBLISH : S_IDLE;
                end
                S_PUBLISH: begin
                    o_Live         <= r_win_fault ? 8'hFF : w_live;
                    o_Sensor_Fault <= r_win_fault;
                    o_Live_Valid   <= 1'b1;
                    r_acc          <= '0;
                    r_count        <= '0;
                    r_win_fault    <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temperature_sensor_reader.sv
// tb/tb_temperature_sensor_reader.sv - scoreboard bench: ADC models, reference averaging model, protocol checks
module tb_temperature_sensor_reader;

    localparam int NI    = 4;
    localparam int CD    = 2;
    localparam int DEPTH = 16;
    localparam int P_SP  [NI] = '{1000, 200, 200, 40};
    localparam int P_OFF [NI] = '{0, 600, 0, 0};
    localparam int P_SH  [NI] = '{2, 2, 0, 2};

    logic          clk  = 1'b0;
    logic [NI-1:0] rst  = '1;
    logic [NI-1:0] miso = '0;
    logic [NI-1:0] sclk, mosi, cs_n, vld, flt;
    logic [7:0]    live [NI];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    bit chk_final = 1'b0;
    bit tmo = 1'b0;

    int nfall [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        temperature_sensor_reader #(
            .CLK_DIV      (CD),
            .SAMPLE_PERIOD(P_SP[g]),
            .AVG_LOG2     (3),
            .ADC_OFFSET   (P_OFF[g]),
            .ADC_SHIFT    (P_SH[g])
        ) u_dut (
            .i_Clock50MHz  (clk),
            .i_Reset       (rst[g]),
            .i_Adc_Miso    (miso[g]),
            .o_Adc_Sclk    (sclk[g]),
            .o_Adc_Mosi    (mosi[g]),
            .o_Adc_Cs_n    (cs_n[g]),
            .o_Live        (live[g]),
            .o_Live_Valid  (vld[g]),
            .o_Sensor_Fault(flt[g])
        );
    end

    task automatic chk(input int inst, input string nm, input int act_v, input int exp_v);
        n_vec++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, inst, act_v, exp_v);
        end
    endtask

    // Instance 0 sample script: constant, ramp, one railed sample, clean, then railed partial window
    function automatic logic [9:0] stim0(input int k);
        if (k < 8)   return 10'd512;
        if (k < 16)  return 10'(92 + k);
        if (k == 19) return 10'h3FF;
        if (k < 32)  return 10'd512;
        if (k < 36)  return 10'h3FF;
        return 10'd512;
    endfunction

    function automatic int ref_live(input int sum, input int off, input int sh);
        int avg, d, s;
        avg = sum / 8;
        d   = (avg > off) ? avg - off : 0;
        s   = d >> sh;
        return (s > 255) ? 255 : s;
    endfunction

    // ADC models, reference model and output monitor
    initial begin
        int msum [NI], mcnt [NI], npub [NI], rises [NI];
        int fall_t [NI], rise_t [NI], rel_cyc [NI], wr [NI], rd [NI], held [NI];
        int exp_live [NI][DEPTH], exp_flt [NI][DEPTH], exp_t [NI][DEPTH];
        bit mflt [NI], act [NI], lf_ok [NI], rs_ok [NI], first_pend [NI], rst_seen [NI];
        bit prev_cs [NI], prev_sclk [NI];
        logic [3:0] mbits [NI];
        logic [9:0] val [NI];
        int sidx, r, slot;
        bit fin_done;
        sidx = 0;
        fin_done = 1'b0;
        for (int i = 0; i < NI; i++) begin
            msum[i] = 0; mcnt[i] = 0; npub[i] = 0; rises[i] = 0; nfall[i] = 0;
            fall_t[i] = 0; rise_t[i] = 0; rel_cyc[i] = 0; wr[i] = 0; rd[i] = 0; held[i] = 255;
            mflt[i] = 0; act[i] = 0; lf_ok[i] = 0; rs_ok[i] = 0; first_pend[i] = 0; rst_seen[i] = 0;
            prev_cs[i] = 1; prev_sclk[i] = 0; mbits[i] = '0; val[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst[i]) begin
                    if (!rst_seen[i]) begin
                        chk(i, "rst_cs_n", int'(cs_n[i]), 1);
                        chk(i, "rst_sclk", int'(sclk[i]), 0);
                        chk(i, "rst_mosi", int'(mosi[i]), 0);
                        chk(i, "rst_live", int'(live[i]), 255);
                        chk(i, "rst_valid", int'(vld[i]), 0);
                        chk(i, "rst_fault", int'(flt[i]), 0);
                        rst_seen[i] = 1'b1;
                    end
                    msum[i] = 0; mcnt[i] = 0; mflt[i] = 0; act[i] = 0;
                    lf_ok[i] = 0; rs_ok[i] = 0; rd[i] = wr[i]; held[i] = 255;
                    miso[i] = 1'b0;
                end else begin
                    if (rst_seen[i]) begin
                        rst_seen[i] = 1'b0;
                        rel_cyc[i] = cyc;
                        first_pend[i] = 1'b1;
                    end
                    if (prev_cs[i] && !cs_n[i]) begin
                        nfall[i]++;
                        if (first_pend[i]) begin
                            chk(i, "first_req_latency", cyc - rel_cyc[i], P_SP[i]);
                            first_pend[i] = 1'b0;
                        end
                        if (lf_ok[i]) chk(i, "req_align", (cyc - fall_t[i]) % P_SP[i], 0);
                        if (rs_ok[i]) chk(i, "cs_high_gap_ok", int'((cyc - rise_t[i]) >= CD), 1);
                        fall_t[i] = cyc; lf_ok[i] = 1; act[i] = 1; rises[i] = 0; mbits[i] = '0;
                        case (i)
                            0: begin val[i] = stim0(sidx); sidx++; end
                            1: val[i] = 10'd512;
                            2: val[i] = 10'd1000;
                            default: begin
                                if ($urandom_range(0, 31) == 0) val[i] = ($urandom_range(0, 1) == 1) ? 10'h3FF : 10'h000;
                                else val[i] = 10'($urandom_range(1, 1022));
                            end
                        endcase
                        miso[i] = 1'b0;
                    end
                    if (act[i] && !prev_sclk[i] && sclk[i]) begin
                        if (rises[i] < 4) mbits[i][3 - rises[i]] = mosi[i];
                        rises[i]++;
                    end
                    if (act[i] && prev_sclk[i] && !sclk[i]) begin
                        r = rises[i];
                        miso[i] = (r >= 5 && r <= 14) ? val[i][14 - r] : 1'b0;
                    end
                    if (act[i] && !prev_cs[i] && cs_n[i]) begin
                        chk(i, "sclk_rises", rises[i], 16);
                        chk(i, "mosi_cmd", int'(mbits[i]), 13);
                        chk(i, "cs_low_clks", cyc - fall_t[i], 33 * CD);
                        act[i] = 0; rise_t[i] = cyc; rs_ok[i] = 1;
                        msum[i] += int'(val[i]);
                        if (val[i] == 10'h000 || val[i] == 10'h3FF) mflt[i] = 1'b1;
                        mcnt[i]++;
                        if (mcnt[i] == 8) begin
                            slot = wr[i] % DEPTH;
                            exp_live[i][slot] = mflt[i] ? 255 : ref_live(msum[i], P_OFF[i], P_SH[i]);
                            exp_flt[i][slot]  = int'(mflt[i]);
                            exp_t[i][slot]    = cyc + CD + 2;
                            wr[i]++;
                            msum[i] = 0; mcnt[i] = 0; mflt[i] = 0;
                        end
                    end
                    if (vld[i]) begin
                        if (rd[i] == wr[i]) begin
                            chk(i, "unexpected_valid", 1, 0);
                        end else begin
                            slot = rd[i] % DEPTH;
                            chk(i, "live", int'(live[i]), exp_live[i][slot]);
                            chk(i, "fault", int'(flt[i]), exp_flt[i][slot]);
                            chk(i, "publish_cycle", cyc, exp_t[i][slot]);
                            rd[i]++;
                        end
                        npub[i]++;
                        held[i] = int'(live[i]);
                    end else if (int'(live[i]) != held[i]) begin
                        chk(i, "live_changed_without_valid", int'(live[i]), held[i]);
                        held[i] = int'(live[i]);
                    end
                end
                prev_cs[i] = cs_n[i];
                prev_sclk[i] = sclk[i];
            end
            if (chk_final && !fin_done) begin
                fin_done = 1'b1;
                chk(0, "publish_count", npub[0], 5);
                chk(0, "timeout", int'(tmo), 0);
                for (int i = 0; i < NI; i++) begin
                    chk(i, "publish_overdue", int'(rd[i] != wr[i] && exp_t[i][rd[i] % DEPTH] < cyc), 0);
                end
            end
        end
    end

    initial begin
        int guard;
        guard = 0;
        repeat (5) @(posedge clk);
        #2 rst = '0;
        while (nfall[0] < 36 && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 60000) tmo = 1'b1;
        // land inside SHIFT of the interrupted frame
        repeat (12) @(posedge clk);
        #1 rst[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst[0] = 1'b0;
        repeat (10000) @(posedge clk);
        chk_final = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
